// File: rtl/seg7_display_mux_n.sv
// N-digit time-multiplexed 7-segment driver with dead-time, PWM brightness,
// per-digit blink and leading-zero blanking; all outputs registered, active-low.
module seg7_display_mux_n #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 2,
    parameter int BR_W        = 3,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5*N_DIGITS-1:0] digits_in,
    input  logic                  blank_lz,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic [BR_W-1:0]       brightness,
    output logic [N_DIGITS-1:0]   seg_select,
    output logic [7:0]            dec_out
);

    localparam int PS_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int BL_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int DW    = 5;

    logic [PS_W-1:0]     prescaler_r;
    logic [IDX_W-1:0]    index_r;
    logic [BL_W-1:0]     blink_cnt_r;
    logic                blink_phase_r;
    logic [N_DIGITS-1:0] seg_select_r;
    logic [7:0]          dec_out_r;

    logic                tick_s;
    logic                round_end_s;
    logic [4:0]          cur_digit_s;
    logic [N_DIGITS-1:0] lz_s;
    logic [N_DIGITS-1:0] blank_s;
    logic                lz_run_s;
    logic                lit_s;
    logic [N_DIGITS-1:0] anode_s;

    function automatic logic [7:0] seg7_decode(input logic [4:0] d);
        logic [7:0] c;
        case (d[3:0])
            4'h0:    c = 8'hC0;
            4'h1:    c = 8'hF9;
            4'h2:    c = 8'hA4;
            4'h3:    c = 8'hB0;
            4'h4:    c = 8'h99;
            4'h5:    c = 8'h92;
            4'h6:    c = 8'h82;
            4'h7:    c = 8'hF8;
            4'h8:    c = 8'h80;
            4'h9:    c = 8'h90;
            4'hA:    c = 8'h88;
            4'hB:    c = 8'h83;
            4'hC:    c = 8'hC6;
            4'hD:    c = 8'hA1;
            4'hE:    c = 8'h86;
            4'hF:    c = 8'h8E;
            default: c = 8'hFF;
        endcase
        return d[4] ? (c & 8'h7F) : c;
    endfunction

    assign tick_s      = (prescaler_r == PS_W'(REFRESH_DIV - 1));
    // Blink advances once per full scan so every digit sees whole rounds of each phase.
    assign round_end_s = tick_s && (index_r == IDX_W'(N_DIGITS - 1));
    assign cur_digit_s = digits_in[index_r*DW +: DW];

    // Slot prescaler, digit index and blink phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_r   <= '0;
            index_r       <= '0;
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else begin
            prescaler_r <= tick_s ? '0 : prescaler_r + PS_W'(1);
            if (tick_s) begin
                index_r <= (index_r == IDX_W'(N_DIGITS - 1)) ? '0 : index_r + IDX_W'(1);
            end
            if (round_end_s) begin
                if (blink_cnt_r == BL_W'(BLINK_TICKS - 1)) begin
                    blink_cnt_r   <= '0;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + BL_W'(1);
                end
            end
        end
    end

    // Leading-zero run from the top digit down; digit 0 always stays visible.
    always_comb begin
        lz_s     = '0;
        lz_run_s = blank_lz;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lz_run_s = lz_run_s & (digits_in[i*DW +: DW] == 5'h00);
            lz_s[i]  = lz_run_s;
        end
        blank_s = lz_s | (blink_mask & {N_DIGITS{blink_phase_r}});
    end

    // Lit window: past dead-time, inside the PWM duty and digit not blanked.
    always_comb begin
        lit_s = (prescaler_r >= PS_W'(DEAD_CYCLES)) &&
                (prescaler_r[BR_W-1:0] <= brightness) &&
                !blank_s[index_r];
        for (int i = 0; i < N_DIGITS; i++) begin
            anode_s[i] = !(lit_s && (index_r == IDX_W'(i)));
        end
    end

    // Anode and cathode registers update together so no ghost pattern leaks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_select_r <= '1;
            dec_out_r    <= 8'hFF;
        end else begin
            seg_select_r <= anode_s;
            dec_out_r    <= lit_s ? seg7_decode(cur_digit_s) : 8'hFF;
        end
    end

    assign seg_select = seg_select_r;
    assign dec_out    = dec_out_r;

endmodule

// File: tb/tb_seg7_display_mux_n.sv
// Self-checking bench for seg7_display_mux_n (4 digits, 8-clock slots, 1 dead cycle,
// 2-bit brightness, blink half-period of 2 scan rounds).
module tb_seg7_display_mux_n;

    localparam int N  = 4;
    localparam int RD = 8;

    typedef struct {
        logic [19:0]     digits;
        logic            blz;
        logic [3:0]      mask;
        logic [1:0]      br;
        logic [3:0][7:0] cath;
        string           name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] digits_in = 20'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = 4'h0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  seg_select;
    logic [7:0]  dec_out;

    int tests_run = 0;
    int tests_failed = 0;
    logic [11:0] exp_q[$];
    vec_t vecs[10];

    seg7_display_mux_n #(
        .N_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(1), .BR_W(2), .BLINK_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .blank_lz(blank_lz),
        .blink_mask(blink_mask), .brightness(brightness),
        .seg_select(seg_select), .dec_out(dec_out)
    );

    always #5 clk = ~clk;

    // Expected {anodes, cathodes} for the k-th registered sample after reset release.
    function automatic logic [11:0] model(input int k, input logic [3:0][7:0] cath,
                                          input logic [1:0] br, input logic [3:0] mask);
        int p;
        int s;
        int ph;
        logic [7:0] c;
        logic lit;
        p  = k % RD;
        s  = (k / RD) % N;
        ph = (k / (RD * N * 2)) % 2;
        c  = cath[s];
        if (mask[s] && ph == 1) c = 8'hFF;
        lit = (p >= 1) && ((p % 4) <= int'(br)) && (c != 8'hFF);
        return lit ? {~(4'b0001 << s), c} : {4'b1111, 8'hFF};
    endfunction

    task automatic check(input string tag, input int k, input logic [11:0] expv);
        tests_run++;
        if ({seg_select, dec_out} !== expv) begin
            tests_failed++;
            $display("FAIL %s k=%0d seg_select=%b dec_out=%h expected seg_select=%b dec_out=%h",
                     tag, k, seg_select, dec_out, expv[11:8], expv[7:0]);
        end
    endtask

    task automatic do_reset(input logic [19:0] d, input logic blz, input logic [3:0] m,
                            input logic [1:0] br);
        @(negedge clk);
        rst        = 1'b1;
        digits_in  = d;
        blank_lz   = blz;
        blink_mask = m;
        brightness = br;
        #1;
        check("reset_state", -1, 12'hFFF);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int k0, input int n, input logic [3:0][7:0] cath,
                       input logic [1:0] br, input logic [3:0] mask, input string tag);
        for (int j = 0; j < n; j++) begin
            exp_q.push_back(model(k0 + j, cath, br, mask));
            @(posedge clk);
            #1;
            check(tag, k0 + j, exp_q.pop_front());
        end
    endtask

    initial begin
        int cnt;
        int blink_exp[5];
        logic [3:0][7:0] c2;

        vecs[0] = '{20'b00011_00010_00001_00000, 1'b0, 4'h0, 2'd3, {8'hB0, 8'hA4, 8'hF9, 8'hC0}, "plain_br3"};
        vecs[1] = '{20'b00011_00010_00001_00000, 1'b0, 4'h0, 2'd1, {8'hB0, 8'hA4, 8'hF9, 8'hC0}, "plain_br1"};
        vecs[2] = '{20'b00000_00000_00101_00000, 1'b1, 4'h0, 2'd3, {8'hFF, 8'hFF, 8'h92, 8'hC0}, "lz_basic"};
        vecs[3] = '{20'b10000_00000_00101_00000, 1'b1, 4'h0, 2'd3, {8'h40, 8'hC0, 8'h92, 8'hC0}, "lz_dot_top"};
        vecs[4] = '{20'b00000_00000_00000_00000, 1'b1, 4'h0, 2'd2, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, "lz_all_zero"};
        vecs[5] = '{20'b01111_01110_11101_01100, 1'b0, 4'h0, 2'd0, {8'h8E, 8'h86, 8'h21, 8'hC6}, "hex_cdef_br0"};
        vecs[6] = '{20'b01010_01011_01001_01000, 1'b0, 4'h0, 2'd2, {8'h88, 8'h83, 8'h90, 8'h80}, "hex_89ab_br2"};
        vecs[7] = '{20'b00111_00110_00101_00100, 1'b1, 4'h0, 2'd3, {8'hF8, 8'h82, 8'h92, 8'h99}, "hex_4567_lz"};
        vecs[8] = '{20'b00000_00000_00000_00001, 1'b1, 4'hF, 2'd3, {8'hFF, 8'hFF, 8'hFF, 8'hF9}, "lz_blink_ph0"};
        vecs[9] = '{20'b00000_10000_00000_00000, 1'b1, 4'h0, 2'd3, {8'hFF, 8'h40, 8'hC0, 8'hC0}, "lz_dot_mid"};

        // Table vectors: one full scan plus the wrap back to digit 0.
        for (int v = 0; v < 10; v++) begin
            do_reset(vecs[v].digits, vecs[v].blz, vecs[v].mask, vecs[v].br);
            run(0, 40, vecs[v].cath, vecs[v].br, vecs[v].mask, vecs[v].name);
        end

        // Blink on digit 1: lit cycles per scan round.
        blink_exp = '{7, 7, 0, 0, 7};
        do_reset(vecs[0].digits, 1'b0, 4'b0010, 2'd3);
        for (int r = 0; r < 5; r++) begin
            cnt = 0;
            for (int j = 0; j < 32; j++) begin
                @(posedge clk);
                #1;
                if (seg_select == 4'b1101 && dec_out == 8'hF9) cnt++;
            end
            tests_run++;
            if (cnt != blink_exp[r]) begin
                tests_failed++;
                $display("FAIL blink_round%0d lit_cycles=%0d expected %0d", r, cnt, blink_exp[r]);
            end
        end

        // Blink with the cycle model over five rounds, digits 0/2/3 steady.
        do_reset(vecs[0].digits, 1'b0, 4'b0010, 2'd3);
        run(0, 160, vecs[0].cath, 2'd3, 4'b0010, "blink_model");

        // Digit inputs are sampled every clock, not latched per slot.
        do_reset(vecs[0].digits, 1'b0, 4'h0, 2'd3);
        run(0, 4, vecs[0].cath, 2'd3, 4'h0, "live_pre");
        digits_in[3:0] = 4'h8;
        c2 = vecs[0].cath;
        c2[0] = 8'h80;
        run(4, 8, c2, 2'd3, 4'h0, "live_post");

        // Asynchronous reset in the middle of digit 2's slot.
        do_reset(vecs[0].digits, 1'b0, 4'h0, 2'd3);
        run(0, 21, vecs[0].cath, 2'd3, 4'h0, "pre_midrst");
        #1;
        rst = 1'b1;
        #1;
        check("midslot_reset_async", -1, 12'hFFF);
        @(negedge clk);
        rst = 1'b0;
        run(0, 12, vecs[0].cath, 2'd3, 4'h0, "post_midrst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
